viterbi_window_ctrl: RTL and testbench

- Sequencing controller for the survivor-path selector in the Viterbi decoder.
- Accepts symbol beats from the ACS stage and drives the selector's valid_in, write_pointer and refresh.
- Pads each frame out to a full 8-symbol window, then collects the selector's selected_path at each window end into a 2-entry output FIFO.
- Frames are started by the top-level decoder FSM; decoded bytes go to the output packer.

---
 rtl/viterbi_window_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_viterbi_window_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_window_ctrl.sv
// Purpose: sequences survivor-path selector beats, pads frames to 8-symbol windows, buffers window bytes.
// Latency: beat issue is registered (sel_valid_in one cycle after accept); bytes appear as the wp=7 beat returns.
// Backpressure: acs_ready drops when MAX_OUT beats are in flight or two window ends are buffered or pending.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, frame_len, busy, done  frame control from the decoder FSM; err is sticky until rst
//   acs_valid/acs_ready, pad_en   symbol beats from ACS; pad_en marks zero-metric pad beats
//   sel_*                         selector issue (valid_in, write_pointer, refresh) and return
//   dec_valid/dec_data/dec_ready  decoded byte stream towards the output packer
module viterbi_window_ctrl #(
    parameter int LEN_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             acs_valid,
    output logic             acs_ready,
    output logic             pad_en,
    output logic             sel_valid_in,
    output logic [2:0]       sel_write_pointer,
    output logic             sel_refresh,
    input  logic             sel_valid_out,
    input  logic [2:0]       sel_write_pointer_out,
    input  logic [7:0]       sel_selected_path,
    output logic             dec_valid,
    output logic [7:0]       dec_data,
    input  logic             dec_ready
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         wp_q, wp_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [1:0]         pend_q, pend_d;
    logic [2:0]         exp_wp_q, exp_wp_d;
    logic [7:0]         fifo_mem_q [2];
    logic [7:0]         fifo_mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               vld_in_q, vld_in_d;
    logic [2:0]         sel_wp_q, sel_wp_d;
    logic               refresh_q, refresh_d;
    logic               pad_q, pad_d;

    logic issue_ok, run_fire, pad_fire, fire, last_run, drain_ok, start_ok, start_zero;
    logic ret_ok, ret_err, push, pop, push_drop, push_do, pend_inc, pend_dec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            // Last symbol: a frame ending exactly on a window edge needs no padding.
            S_RUN:   if (last_run) state_d = (wp_q == 3'd7) ? S_DRAIN : S_FLUSH;
            S_FLUSH: if (pad_fire && wp_q == 3'd7) state_d = S_DRAIN;
            S_DRAIN: if (drain_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and issue qualification
    always_comb begin
        // Window ends already buffered plus those still in the selector must fit the 2-entry FIFO.
        issue_ok   = (outst_q < OUT_W'(MAX_OUT))
                     && (({1'b0, fifo_cnt_q} + {1'b0, pend_q}) < 3'd2);
        acs_ready  = (state_q == S_RUN) && issue_ok;
        run_fire   = acs_ready && acs_valid;
        pad_fire   = (state_q == S_FLUSH) && issue_ok;
        fire       = run_fire || pad_fire;
        last_run   = run_fire && (cnt_q == len_q - LEN_W'(1));
        drain_ok   = (state_q == S_DRAIN) && (outst_q == '0) && (fifo_cnt_q == 2'd0);
        start_ok   = (state_q == S_IDLE) && start && (frame_len != '0);
        start_zero = (state_q == S_IDLE) && start && (frame_len == '0);
        busy       = (state_q != S_IDLE);
        done_d     = start_zero || drain_ok;
    end

    // Datapath: counters, return checking, output FIFO
    always_comb begin
        // Returns are only meaningful inside a frame; anything seen in IDLE is stale.
        ret_ok    = sel_valid_out && busy && (outst_q != '0);
        ret_err   = sel_valid_out && busy && (outst_q == '0);
        push      = ret_ok && (sel_write_pointer_out == 3'd7);
        pop       = dec_valid && dec_ready;
        push_drop = push && (fifo_cnt_q == 2'd2) && !pop;
        push_do   = push && !push_drop;
        pend_inc  = fire && (wp_q == 3'd7);
        pend_dec  = push && (pend_q != 2'd0);

        wp_d     = wp_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        exp_wp_d = exp_wp_q;
        if (start_ok) begin
            wp_d     = 3'd0;
            cnt_d    = '0;
            len_d    = frame_len;
            exp_wp_d = 3'd0;
        end else begin
            if (fire)     wp_d = wp_q + 3'd1;
            if (run_fire) cnt_d = cnt_q + LEN_W'(1);
            if (ret_ok)   exp_wp_d = exp_wp_q + 3'd1;
        end

        outst_d = outst_q;
        case ({fire, ret_ok})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        pend_d = pend_q;
        case ({pend_inc, pend_dec})
            2'b10:   pend_d = pend_q + 2'd1;
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_do) begin
            fifo_mem_d[wr_ptr_q] = sel_selected_path;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push_do, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // A mismatched return still advances expected_wp so one glitch flags once.
        err_d = err_q || ret_err || push_drop
                || (ret_ok && (sel_write_pointer_out != exp_wp_q));

        vld_in_d  = fire;
        sel_wp_d  = fire ? wp_q : 3'd0;
        refresh_d = fire && (wp_q == 3'd7);
        pad_d     = pad_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q          <= 3'd0;
            cnt_q         <= '0;
            len_q         <= '0;
            outst_q       <= '0;
            pend_q        <= 2'd0;
            exp_wp_q      <= 3'd0;
            fifo_mem_q[0] <= 8'd0;
            fifo_mem_q[1] <= 8'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            vld_in_q      <= 1'b0;
            sel_wp_q      <= 3'd0;
            refresh_q     <= 1'b0;
            pad_q         <= 1'b0;
        end else begin
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            outst_q       <= outst_d;
            pend_q        <= pend_d;
            exp_wp_q      <= exp_wp_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            err_q         <= err_d;
            done_q        <= done_d;
            vld_in_q      <= vld_in_d;
            sel_wp_q      <= sel_wp_d;
            refresh_q     <= refresh_d;
            pad_q         <= pad_d;
        end
    end

    assign done              = done_q;
    assign err               = err_q;
    assign pad_en            = pad_q;
    assign sel_valid_in      = vld_in_q;
    assign sel_write_pointer = sel_wp_q;
    assign sel_refresh       = refresh_q;
    assign dec_valid         = (fifo_cnt_q != 2'd0);
    assign dec_data          = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_viterbi_window_ctrl.sv
// Purpose: directed bench for viterbi_window_ctrl with a behavioural selector of settable latency.
// Latency: selector model returns each beat 1..4 cycles after sel_valid_in.
// Backpressure: dec_ready and acs_valid are driven per scenario.
module tb_viterbi_window_ctrl;
    localparam int LEN_W   = 8;
    localparam int MAX_OUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             busy, done, err;
    logic             acs_valid = 1'b0;
    logic             acs_ready, pad_en;
    logic             sel_valid_in, sel_refresh;
    logic [2:0]       sel_write_pointer;
    logic             sel_valid_out;
    logic [2:0]       sel_write_pointer_out;
    logic [7:0]       sel_selected_path;
    logic             dec_valid;
    logic [7:0]       dec_data;
    logic             dec_ready = 1'b0;

    viterbi_window_ctrl #(.LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .err(err),
        .acs_valid(acs_valid), .acs_ready(acs_ready), .pad_en(pad_en),
        .sel_valid_in(sel_valid_in), .sel_write_pointer(sel_write_pointer),
        .sel_refresh(sel_refresh), .sel_valid_out(sel_valid_out),
        .sel_write_pointer_out(sel_write_pointer_out),
        .sel_selected_path(sel_selected_path),
        .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Selector model and injection path
    int         lat = 1;
    logic       model_on = 1'b1;
    logic       st_v [1:4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] st_w [1:4] = '{3'd0, 3'd0, 3'd0, 3'd0};
    logic       m_vld = 1'b0;
    logic [2:0] m_wp = 3'd0;
    logic [7:0] m_path = 8'd0;
    int         ret_cnt = 0;
    int         ret_base = 0;
    logic [7:0] path_base = 8'd0;
    logic       inj_vld = 1'b0;
    logic [2:0] inj_wp = 3'd0;
    logic [7:0] inj_path = 8'd0;

    assign sel_valid_out         = model_on ? m_vld  : inj_vld;
    assign sel_write_pointer_out = model_on ? m_wp   : inj_wp;
    assign sel_selected_path     = model_on ? m_path : inj_path;

    // Observation records
    int   iss_wp[$];
    int   iss_cyc[$];
    bit   iss_pad[$];
    bit   iss_ref[$];
    logic [7:0] byte_q[$];
    int   byte_cyc[$];
    int   done_cyc[$];
    bit   done_busy[$];
    int   vin_tot = 0, vout_tot = 0, out_now = 0;
    int   stall_cnt = 0, over_cnt = 0, atmax_cnt = 0, last_ret_cyc = 0;

    always @(negedge clk) begin
        if (sel_valid_in) begin
            iss_wp.push_back(int'(sel_write_pointer));
            iss_cyc.push_back(cyc);
            iss_pad.push_back(pad_en);
            iss_ref.push_back(sel_refresh);
            vin_tot++;
        end
        if (dec_valid && dec_ready) begin
            byte_q.push_back(dec_data);
            byte_cyc.push_back(cyc);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
        end
        if (sel_valid_out) begin
            vout_tot++;
            last_ret_cyc = cyc;
        end
        out_now = vin_tot - vout_tot;
        if (busy && acs_valid && !acs_ready) stall_cnt++;
        if (out_now > MAX_OUT || (acs_ready && out_now >= MAX_OUT)) over_cnt++;
        if (out_now == MAX_OUT) atmax_cnt++;
        m_vld = st_v[lat];
        m_wp  = st_w[lat];
        if (m_vld) begin
            m_path = path_base + 8'(ret_cnt - ret_base);
            ret_cnt++;
        end
        for (int i = 4; i > 1; i--) begin
            st_v[i] = st_v[i-1];
            st_w[i] = st_w[i-1];
        end
        st_v[1] = sel_valid_in;
        st_w[1] = sel_write_pointer;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len);
        tick();
        start = 1'b1;
        frame_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, err, acs_ready, pad_en, sel_valid_in, sel_refresh, dec_valid} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {busy, done, err, acs_ready, pad_en, sel_valid_in, sel_refresh, dec_valid});
        end
        checks++;
        if ({sel_write_pointer, dec_data} !== 11'd0) begin
            failures++;
            $display("FAIL reset_data: wp=%0d data=%0h expected 0 0", sel_write_pointer, dec_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, acs_ready} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b acs_ready=%b expected 0 0", busy, acs_ready);
        end
    endtask

    task automatic test_basic();
        int si, sb, sd, bad;
        bit ok;
        lat = 1; model_on = 1'b1; dec_ready = 1'b1;
        path_base = 8'h20; ret_base = ret_cnt;
        si = iss_wp.size(); sb = byte_q.size(); sd = done_cyc.size();
        acs_valid = 1'b1;
        start_frame(8);
        wait_done(100, ok);
        acs_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done_timeout: no done within 100 cycles"); end
        checks++;
        if (iss_wp.size() - si != 8) begin
            failures++; $display("FAIL basic_beats: got %0d expected 8", iss_wp.size() - si);
        end
        bad = 0;
        for (int i = 0; i < 8 && si + i < iss_wp.size(); i++) begin
            if (iss_wp[si+i] != i || iss_cyc[si+i] != iss_cyc[si] + i
                || iss_ref[si+i] != (i == 7) || iss_pad[si+i]) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL basic_beat_seq: %0d bad beats expected 0", bad); end
        checks++;
        if (byte_q.size() - sb != 1 || byte_q[sb] !== 8'h27) begin
            failures++;
            $display("FAIL basic_byte: count=%0d first=%0h expected 1 27", byte_q.size() - sb, byte_q[sb]);
        end
        checks++;
        if (done_cyc.size() - sd != 1 || done_busy[sd] != 1'b0) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d busy_at_done=%0d expected 1 0",
                     done_cyc.size() - sd, done_busy[sd]);
        end
        checks++;
        if ({err, busy} !== 2'b00) begin
            failures++; $display("FAIL basic_end_state: err=%b busy=%b expected 0 0", err, busy);
        end
    endtask

    task automatic test_flush();
        int si, sb, sd, bad;
        bit ok;
        lat = 1; dec_ready = 1'b1;
        path_base = 8'h40; ret_base = ret_cnt;
        si = iss_wp.size(); sb = byte_q.size(); sd = done_cyc.size();
        acs_valid = 1'b1;
        start_frame(10);
        wait_done(100, ok);
        acs_valid = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL flush_done_timeout: no done within 100 cycles"); end
        checks++;
        if (iss_wp.size() - si != 16) begin
            failures++; $display("FAIL flush_beats: got %0d expected 16", iss_wp.size() - si);
        end
        bad = 0;
        for (int i = 0; i < 16 && si + i < iss_wp.size(); i++) begin
            if (iss_wp[si+i] != i % 8 || iss_pad[si+i] != (i >= 10)
                || iss_ref[si+i] != (i % 8 == 7) || iss_cyc[si+i] != iss_cyc[si] + i) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL flush_beat_seq: %0d bad beats expected 0", bad); end
        checks++;
        if (byte_q.size() - sb != 2 || byte_q[sb] !== 8'h47 || byte_q[sb+1] !== 8'h4F) begin
            failures++;
            $display("FAIL flush_bytes: count=%0d b0=%0h b1=%0h expected 2 47 4f",
                     byte_q.size() - sb, byte_q[sb], byte_q[sb+1]);
        end
        checks++;
        if (done_cyc.size() - sd != 1 || done_cyc[sd] <= byte_cyc[sb+1]) begin
            failures++;
            $display("FAIL flush_done_order: done_cyc=%0d last_pop_cyc=%0d expected done later",
                     done_cyc[sd], byte_cyc[sb+1]);
        end
    endtask

    task automatic test_backpressure();
        int si, sb, st, rcyc, early;
        bit ok;
        lat = 1; dec_ready = 1'b0;
        path_base = 8'h10; ret_base = ret_cnt;
        si = iss_wp.size(); sb = byte_q.size(); st = stall_cnt;
        acs_valid = 1'b1;
        start_frame(24);
        repeat (38) tick();
        rcyc = cyc;
        dec_ready = 1'b1;
        wait_done(200, ok);
        acs_valid = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_done_timeout: no done within 200 cycles"); end
        early = 0;
        for (int i = si; i < iss_cyc.size(); i++) if (iss_cyc[i] <= rcyc) early++;
        checks++;
        if (early != 16) begin
            failures++; $display("FAIL bp_beats_before_ready: got %0d expected 16", early);
        end
        checks++;
        if (iss_wp.size() - si != 24 || stall_cnt - st == 0) begin
            failures++;
            $display("FAIL bp_beats_stall: beats=%0d stalls=%0d expected 24 nonzero",
                     iss_wp.size() - si, stall_cnt - st);
        end
        checks++;
        if (byte_q.size() - sb != 3 || byte_q[sb] !== 8'h17 || byte_q[sb+1] !== 8'h1F
            || byte_q[sb+2] !== 8'h27) begin
            failures++;
            $display("FAIL bp_bytes: count=%0d b0=%0h b1=%0h b2=%0h expected 3 17 1f 27",
                     byte_q.size() - sb, byte_q[sb], byte_q[sb+1], byte_q[sb+2]);
        end
        checks++;
        if (byte_cyc[sb] < rcyc || err !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop_timing: first_pop=%0d ready_cyc=%0d err=%b expected pop>=ready err 0",
                     byte_cyc[sb], rcyc, err);
        end
    endtask

    task automatic test_latency();
        int si, sb, sd, st, so, sm, bad;
        bit ok;
        lat = 4; dec_ready = 1'b1;
        path_base = 8'h60; ret_base = ret_cnt;
        si = iss_wp.size(); sb = byte_q.size(); sd = done_cyc.size();
        st = stall_cnt; so = over_cnt; sm = atmax_cnt;
        acs_valid = 1'b1;
        start_frame(16);
        wait_done(300, ok);
        acs_valid = 1'b0;
        repeat (2) tick();
        lat = 1;
        checks++;
        if (!ok) begin failures++; $display("FAIL lat_done_timeout: no done within 300 cycles"); end
        bad = 0;
        for (int i = 0; i < 16 && si + i < iss_wp.size(); i++)
            if (iss_wp[si+i] != i % 8 || iss_pad[si+i]) bad++;
        checks++;
        if (iss_wp.size() - si != 16 || bad != 0) begin
            failures++;
            $display("FAIL lat_beats: beats=%0d bad=%0d expected 16 0", iss_wp.size() - si, bad);
        end
        checks++;
        if (over_cnt - so != 0) begin
            failures++; $display("FAIL lat_outstanding_limit: violations=%0d expected 0", over_cnt - so);
        end
        checks++;
        if (atmax_cnt - sm == 0 || stall_cnt - st == 0) begin
            failures++;
            $display("FAIL lat_reach_max: at_max=%0d stalls=%0d expected both nonzero",
                     atmax_cnt - sm, stall_cnt - st);
        end
        checks++;
        if (byte_q.size() - sb != 2 || byte_q[sb] !== 8'h67 || byte_q[sb+1] !== 8'h6F) begin
            failures++;
            $display("FAIL lat_bytes: count=%0d b0=%0h b1=%0h expected 2 67 6f",
                     byte_q.size() - sb, byte_q[sb], byte_q[sb+1]);
        end
        checks++;
        if (done_cyc.size() - sd != 1 || done_cyc[sd] <= last_ret_cyc) begin
            failures++;
            $display("FAIL lat_done_after_return: done_cyc=%0d last_ret=%0d expected done later",
                     done_cyc[sd], last_ret_cyc);
        end
    endtask

    task automatic test_zero_len();
        int si;
        si = iss_wp.size();
        tick();
        start = 1'b1;
        frame_len = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++; $display("FAIL zero_done_pulse: done=%b busy=%b expected 1 0", done, busy);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++; $display("FAIL zero_done_clear: done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (iss_wp.size() != si) begin
            failures++; $display("FAIL zero_no_beats: got %0d beats expected 0", iss_wp.size() - si);
        end
    endtask

    task automatic test_rst_abort();
        int si, sb;
        bit ok;
        lat = 1; model_on = 1'b1; dec_ready = 1'b1;
        acs_valid = 1'b0;
        start_frame(8);
        acs_valid = 1'b1;
        repeat (5) tick();
        acs_valid = 1'b0;
        tick();
        checks++;
        if (iss_wp[iss_wp.size()-1] != 4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_precond: last_wp=%0d busy=%b expected 4 1", iss_wp[iss_wp.size()-1], busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, err, acs_ready, pad_en, sel_valid_in, sel_refresh, dec_valid, sel_write_pointer}
            !== 11'd0) begin
            failures++; $display("FAIL abort_outputs_in_rst: busy=%b svi=%b wp=%0d expected all 0",
                                 busy, sel_valid_in, sel_write_pointer);
        end
        tick();
        rst = 1'b0;
        tick();
        model_on = 1'b0; inj_vld = 1'b1; inj_wp = 3'd7; inj_path = 8'hEE;
        tick();
        inj_vld = 1'b0; model_on = 1'b1;
        tick();
        checks++;
        if ({err, dec_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL stale_return_ignored: err=%b dec_valid=%b busy=%b expected 0 0 0",
                                 err, dec_valid, busy);
        end
        path_base = 8'h80; ret_base = ret_cnt;
        si = iss_wp.size(); sb = byte_q.size();
        acs_valid = 1'b1;
        start_frame(8);
        wait_done(100, ok);
        acs_valid = 1'b0;
        checks++;
        if (!ok || iss_wp.size() - si != 8 || iss_wp[si] != 0) begin
            failures++;
            $display("FAIL restart_beats: done=%0d beats=%0d first_wp=%0d expected 1 8 0",
                     ok, iss_wp.size() - si, iss_wp[si]);
        end
        checks++;
        if (byte_q.size() - sb != 1 || byte_q[sb] !== 8'h87 || err !== 1'b0) begin
            failures++;
            $display("FAIL restart_byte: count=%0d b0=%0h err=%b expected 1 87 0",
                     byte_q.size() - sb, byte_q[sb], err);
        end
    endtask

    task automatic test_err_inject();
        model_on = 1'b0; dec_ready = 1'b1; acs_valid = 1'b0;
        start_frame(8);
        acs_valid = 1'b1;
        repeat (3) tick();
        acs_valid = 1'b0;
        inj_vld = 1'b1; inj_wp = 3'd0;
        tick();
        inj_wp = 3'd1;
        tick();
        inj_vld = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_good_returns: err=%b expected 0", err); end
        inj_vld = 1'b1; inj_wp = 3'd3;
        tick();
        inj_vld = 1'b0;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_wp_mismatch: err=%b expected 1", err); end
        repeat (10) tick();
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: err=%b expected 1", err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_on = 1'b1;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_cleared_by_rst: err=%b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_latency();
        test_zero_len();
        test_rst_abort();
        test_err_inject();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
